// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier feeding the product memory write port.
// One add/shift iteration per clock; product, tag and write-enable are registered.
module seq_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_m,
    input  logic [WIDTH-1:0]     op_q,
    input  logic [WIDTH-1:0]     addr_in,
    output logic                 busy,
    output logic                 done,
    output logic                 we,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     addr_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  m;
    logic              c;
    logic [CW-1:0]     count;

    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  a_next;
    logic [WIDTH-1:0]  q_next;

    // {C,A} = A + M when Q[0] is set, then {C,A,Q} shifts right with 0 into C
    always_comb begin
        sum = {c, a};
        if (q[0]) begin
            sum = {c, a} + {1'b0, m};
        end
        a_next = sum[WIDTH:1];
        q_next = {sum[0], q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a        <= '0;
            q        <= '0;
            m        <= '0;
            c        <= 1'b0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            we       <= 1'b0;
            product  <= '0;
            addr_out <= '0;
        end else begin
            done <= 1'b0;
            we   <= 1'b0;
            if (state == RUN) begin
                a     <= a_next;
                q     <= q_next;
                c     <= 1'b0;
                count <= count - CW'(1);
                if (count == CW'(1)) begin
                    product <= {a_next, q_next};
                    done    <= 1'b1;
                    we      <= 1'b1;
                    busy    <= 1'b0;
                    state   <= DONE;
                end
            end else begin
                // IDLE and DONE both accept a new operation
                if (start) begin
                    m        <= op_m;
                    q        <= op_q;
                    a        <= '0;
                    c        <= 1'b0;
                    count    <= CW'(WIDTH);
                    addr_out <= addr_in;
                    busy     <= 1'b1;
                    state    <= RUN;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult; expected products are queued at stimulus
// time and retired by a monitor whenever the DUT pulses done.
module tb_seq_shift_add_mult;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   op_m;
    logic [W-1:0]   op_q;
    logic [W-1:0]   addr_in;
    logic           busy;
    logic           done;
    logic           we;
    logic [2*W-1:0] product;
    logic [W-1:0]   addr_out;

    int errors = 0;
    int checks = 0;
    int done_count = 0;
    logic [3*W-1:0] sb[$];

    seq_shift_add_mult #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_m     (op_m),
        .op_q     (op_q),
        .addr_in  (addr_in),
        .busy     (busy),
        .done     (done),
        .we       (we),
        .product  (product),
        .addr_out (addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q,
                                             input logic [W-1:0] t);
        logic [2*W-1:0] p;
        p = (2*W)'(m) * (2*W)'(q);
        return {p, t};
    endfunction

    // Scoreboard retirement, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            check("done_in_reset", {31'd0, done}, 32'd0);
            check("we_in_reset", {31'd0, we}, 32'd0);
        end else begin
            check("we_matches_done", {31'd0, we}, {31'd0, done});
            if (done === 1'b1) begin
                done_count++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [3*W-1:0] e;
                    e = sb.pop_front();
                    check("product", {24'd0, product}, {24'd0, e[3*W-1:W]});
                    check("addr_out", {28'd0, addr_out}, {28'd0, e[W-1:0]});
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic [W-1:0] t);
        int n;
        start   = 1'b1;
        op_m    = m;
        op_q    = q;
        addr_in = t;
        sb.push_back(model(m, q, t));
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("latency", n, W);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        rst_n   = 1'b0;
        start   = 1'b0;
        op_m    = '0;
        op_q    = '0;
        addr_in = '0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_product", {24'd0, product}, 32'd0);
        check("rst_addr", {28'd0, addr_out}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic op: busy for four cycles, then a single done cycle
        start   = 1'b1;
        op_m    = 4'b0010;
        op_q    = 4'b1000;
        addr_in = 4'b1000;
        sb.push_back(model(4'b0010, 4'b1000, 4'b1000));
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("no_early_done", {31'd0, done}, 32'd0);
            tick();
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check("product_16", {24'd0, product}, 32'h10);
        tick();
        check("done_cleared", {31'd0, done}, 32'd0);
        tick();

        run_op(4'hF, 4'hF, 4'h3);
        check("product_225", {24'd0, product}, 32'd225);
        run_op(4'h0, 4'hB, 4'h6);
        run_op(4'h7, 4'h1, 4'hF);

        // Operand churn and stray start during RUN
        dc = done_count;
        start   = 1'b1;
        op_m    = 4'h5;
        op_q    = 4'hB;
        addr_in = 4'h3;
        sb.push_back(model(4'h5, 4'hB, 4'h3));
        tick();
        start = 1'b0;
        for (int i = 1; i < W; i++) begin
            op_m    = 4'($urandom);
            op_q    = 4'($urandom);
            addr_in = 4'($urandom);
            start   = 1'b1;
            tick();
        end
        start = 1'b0;
        tick();
        check("churn_done", {31'd0, done}, 32'd1);
        repeat (8) tick();
        check("churn_one_done", done_count - dc, 1);
        check("churn_not_queued", {31'd0, busy}, 32'd0);

        // Back-to-back with start held high
        start   = 1'b1;
        op_m    = 4'd3;
        op_q    = 4'd5;
        addr_in = 4'd1;
        sb.push_back(model(4'd3, 4'd5, 4'd1));
        tick();
        op_m    = 4'd6;
        op_q    = 4'd7;
        addr_in = 4'd2;
        sb.push_back(model(4'd6, 4'd7, 4'd2));
        repeat (W) tick();
        check("b2b_done1", {31'd0, done}, 32'd1);
        check("b2b_busy_low", {31'd0, busy}, 32'd0);
        tick();
        start = 1'b0;
        check("b2b_reloaded", {31'd0, busy}, 32'd1);
        check("b2b_gap", {31'd0, done}, 32'd0);
        repeat (W - 1) tick();
        check("b2b_not_yet", {31'd0, done}, 32'd0);
        tick();
        check("b2b_done2", {31'd0, done}, 32'd1);
        check("product_42", {24'd0, product}, 32'd42);
        tick();
        tick();

        // Asynchronous reset two cycles into RUN
        dc = done_count;
        start   = 1'b1;
        op_m    = 4'd12;
        op_q    = 4'd13;
        addr_in = 4'd5;
        tick();
        start = 1'b0;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_product", {24'd0, product}, 32'd0);
        check("abort_addr", {28'd0, addr_out}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("abort_no_done", done_count - dc, 0);
        run_op(4'd9, 4'd9, 4'd9);
        check("product_81", {24'd0, product}, 32'd81);

        // Long idle: outputs hold
        dc = done_count;
        repeat (20) tick();
        check("idle_no_done", done_count - dc, 0);
        check("idle_product_hold", {24'd0, product}, 32'd81);
        check("idle_addr_hold", {28'd0, addr_out}, 32'd9);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
